// File: rtl/dma_engine_if.sv
// ============================================================================
// dma_engine_if : read/write master bus between the DMA engine and memory
// Revision 1.0
// ============================================================================
`default_nettype none

interface dma_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_ready, rd_valid, rd_data, wr_ready
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_ready, rd_valid, rd_data, wr_ready
  );
endinterface

`default_nettype wire

// File: rtl/dma_engine.sv
// ============================================================================
// dma_engine : single-channel word copier, one outstanding read, no overlap
// Revision 1.0
// ============================================================================
`default_nettype none

module dma_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = 4
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  input  wire logic              start_i,
  input  wire logic [ADDR_W-1:0] src_addr_i,
  input  wire logic [ADDR_W-1:0] dst_addr_i,
  input  wire logic [31:0]       transfer_size_i,
  dma_engine_if.master           bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            words_done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(ADDR_STEP);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [31:0]       remaining_q, remaining_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       words_done_q, words_done_d;
  logic              rd_req, wr_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      remaining_q  <= '0;
      data_q       <= '0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      remaining_q  <= remaining_d;
      data_q       <= data_d;
      words_done_q <= words_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    remaining_d  = remaining_q;
    data_d       = data_q;
    words_done_d = words_done_q;
    rd_req       = 1'b0;
    wr_req       = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d        = src_addr_i;
          dst_d        = dst_addr_i;
          remaining_d  = transfer_size_i;
          words_done_d = '0;
          state_d      = (transfer_size_i == 32'd0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        rd_req = 1'b1;
        busy_o = 1'b1;
        if (bus.rd_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Valid is honoured only here, so a beat coinciding with ready is dropped.
        busy_o = 1'b1;
        if (bus.rd_valid) begin
          data_d  = bus.rd_data;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        wr_req = 1'b1;
        busy_o = 1'b1;
        if (bus.wr_ready) begin
          words_done_d = words_done_q + 32'd1;
          remaining_d  = remaining_q - 32'd1;
          src_d        = src_q + C_STEP;
          dst_d        = dst_q + C_STEP;
          state_d      = (remaining_q == 32'd1) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rd_req   = rd_req;
  assign bus.rd_addr  = src_q;
  assign bus.wr_req   = wr_req;
  assign bus.wr_addr  = dst_q;
  assign bus.wr_data  = data_q;
  assign words_done_o = words_done_q;

endmodule

`default_nettype wire
